// File: rtl/mem_arbiter.sv
// Two-port round-robin memory arbiter: grants one requester at a time, holds the
// memory command for MEM_LATENCY cycles, then returns a single-cycle ack.
module mem_arbiter #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic [31:0] memop,
  output logic [31:0] memaddress,
  output logic [31:0] memoutdata,
  input  logic [31:0] memindata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic [3:0]  LAT      = 4'(MEM_LATENCY);
  localparam logic [31:0] OP_IDLE  = 32'd0;
  localparam logic [31:0] OP_READ  = 32'd1;
  localparam logic [31:0] OP_WRITE = 32'd2;

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic        r_last;
  logic        r_gnt;
  logic [31:0] r_memop;
  logic [31:0] r_memaddress;
  logic [31:0] r_memoutdata;
  logic        r_m0_ack;
  logic        r_m1_ack;
  logic [31:0] r_m0_rdata;
  logic [31:0] r_m1_rdata;

  logic        w_any;
  logic        w_gnt;
  logic        w_we;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;

  // On a tie the port that was not granted last wins (r_last = 1 means port 1).
  assign w_any   = m0_req | m1_req;
  assign w_gnt   = (m0_req && m1_req) ? ~r_last : m1_req;
  assign w_we    = w_gnt ? m1_we    : m0_we;
  assign w_addr  = w_gnt ? m1_addr  : m0_addr;
  assign w_wdata = w_gnt ? m1_wdata : m0_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_last       <= 1'b1;
      r_gnt        <= 1'b0;
      r_memop      <= OP_IDLE;
      r_memaddress <= 32'd0;
      r_memoutdata <= 32'd0;
      r_m0_ack     <= 1'b0;
      r_m1_ack     <= 1'b0;
      r_m0_rdata   <= 32'd0;
      r_m1_rdata   <= 32'd0;
    end else begin
      r_m0_ack <= 1'b0;
      r_m1_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_gnt        <= w_gnt;
            r_last       <= w_gnt;
            r_memop      <= w_we ? OP_WRITE : OP_READ;
            r_memaddress <= w_addr;
            r_memoutdata <= w_wdata;
            r_cnt        <= LAT;
            r_state      <= ACCESS;
          end
        end
        ACCESS: begin
          // Requests are not looked at here, so a dropped req cannot abort the access.
          if (r_cnt <= 4'd1) begin
            r_cnt   <= 4'd0;
            r_memop <= OP_IDLE;
            r_state <= RESP;
            if (r_gnt) begin
              r_m1_ack <= 1'b1;
              if (r_memop == OP_READ) r_m1_rdata <= memindata;
            end else begin
              r_m0_ack <= 1'b1;
              if (r_memop == OP_READ) r_m0_rdata <= memindata;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign memop      = r_memop;
  assign memaddress = r_memaddress;
  assign memoutdata = r_memoutdata;
  assign m0_ack     = r_m0_ack;
  assign m1_ack     = r_m1_ack;
  assign m0_rdata   = r_m0_rdata;
  assign m1_rdata   = r_m1_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances with MEM_LATENCY 1, 3 and 4
// share the requester inputs; each scenario checks the instance it targets.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, memindata;

  logic        m0_ack_o   [3];
  logic        m1_ack_o   [3];
  logic [31:0] m0_rdata_o [3];
  logic [31:0] m1_rdata_o [3];
  logic [31:0] memop_o    [3];
  logic [31:0] memaddr_o  [3];
  logic [31:0] memout_o   [3];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_arbiter #(.MEM_LATENCY(g == 0 ? 1 : (g == 1 ? 3 : 4))) u_dut (
      .clk        (clk),
      .rst        (rst),
      .m0_req     (m0_req),
      .m0_we      (m0_we),
      .m0_addr    (m0_addr),
      .m0_wdata   (m0_wdata),
      .m0_ack     (m0_ack_o[g]),
      .m0_rdata   (m0_rdata_o[g]),
      .m1_req     (m1_req),
      .m1_we      (m1_we),
      .m1_addr    (m1_addr),
      .m1_wdata   (m1_wdata),
      .m1_ack     (m1_ack_o[g]),
      .m1_rdata   (m1_rdata_o[g]),
      .memop      (memop_o[g]),
      .memaddress (memaddr_o[g]),
      .memoutdata (memout_o[g]),
      .memindata  (memindata)
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; memindata = 0;
    tick(); tick();
    for (int g = 0; g < 3; g++) begin
      n_cmp++;
      if (memop_o[g] !== 32'd0 || memaddr_o[g] !== 32'd0 || memout_o[g] !== 32'd0) begin
        n_err++;
        $display("FAIL reset_mem[%0d]: got op=%h addr=%h out=%h, want all 0", g, memop_o[g], memaddr_o[g], memout_o[g]);
      end
      n_cmp++;
      if (m0_ack_o[g] !== 1'b0 || m1_ack_o[g] !== 1'b0 || m0_rdata_o[g] !== 32'd0 || m1_rdata_o[g] !== 32'd0) begin
        n_err++;
        $display("FAIL reset_port[%0d]: got ack0=%b ack1=%b rd0=%h rd1=%h, want all 0", g, m0_ack_o[g], m1_ack_o[g], m0_rdata_o[g], m1_rdata_o[g]);
      end
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (memop_o[0] !== 32'd0) begin
      n_err++;
      $display("FAIL idle_no_req: got memop=%h, want 0", memop_o[0]);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    m0_req = 1; m0_we = 0; m0_addr = 32'h0040_0000; memindata = 32'h3C01_0040;
    tick();
    n_cmp++;
    if (memop_o[0] !== 32'd1 || memaddr_o[0] !== 32'h0040_0000 || m0_ack_o[0] !== 1'b0) begin
      n_err++;
      $display("FAIL read_access: got op=%h addr=%h ack=%b, want op=1 addr=00400000 ack=0", memop_o[0], memaddr_o[0], m0_ack_o[0]);
    end
    tick();
    n_cmp++;
    if (m0_ack_o[0] !== 1'b1 || m0_rdata_o[0] !== 32'h3C01_0040 || m1_ack_o[0] !== 1'b0 || memop_o[0] !== 32'd0) begin
      n_err++;
      $display("FAIL read_ack: got ack0=%b rd0=%h ack1=%b op=%h, want 1 3c010040 0 0", m0_ack_o[0], m0_rdata_o[0], m1_ack_o[0], memop_o[0]);
    end
    m0_req = 0;
    tick();
    n_cmp++;
    if (m0_ack_o[0] !== 1'b0 || memaddr_o[0] !== 32'h0040_0000) begin
      n_err++;
      $display("FAIL read_after: got ack0=%b addr=%h, want 0 00400000", m0_ack_o[0], memaddr_o[0]);
    end
  endtask

  task automatic test_single_write();
    do_reset();
    m1_req = 1; m1_we = 1; m1_addr = 32'h1001_0000; m1_wdata = 32'hDEAD_BEEF; memindata = 32'h5555_AAAA;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (memop_o[1] !== 32'd2 || memout_o[1] !== 32'hDEAD_BEEF || memaddr_o[1] !== 32'h1001_0000 || m1_ack_o[1] !== 1'b0) begin
        n_err++;
        $display("FAIL write_access%0d: got op=%h out=%h addr=%h ack=%b, want 2 deadbeef 10010000 0", i, memop_o[1], memout_o[1], memaddr_o[1], m1_ack_o[1]);
      end
    end
    tick();
    n_cmp++;
    if (m1_ack_o[1] !== 1'b1 || m0_ack_o[1] !== 1'b0 || m1_rdata_o[1] !== 32'd0 || memop_o[1] !== 32'd0) begin
      n_err++;
      $display("FAIL write_ack: got ack1=%b ack0=%b rd1=%h op=%h, want 1 0 0 0", m1_ack_o[1], m0_ack_o[1], m1_rdata_o[1], memop_o[1]);
    end
    m1_req = 0; m1_we = 0;
    tick();
    n_cmp++;
    if (m1_ack_o[1] !== 1'b0 || memout_o[1] !== 32'hDEAD_BEEF || memaddr_o[1] !== 32'h1001_0000) begin
      n_err++;
      $display("FAIL write_idle_hold: got ack1=%b out=%h addr=%h, want 0 deadbeef 10010000", m1_ack_o[1], memout_o[1], memaddr_o[1]);
    end
  endtask

  task automatic test_round_robin();
    int acks, last_c, exp_port;
    rst = 1;
    m0_req = 1; m0_we = 0; m0_addr = 32'h0000_1000;
    m1_req = 1; m1_we = 0; m1_addr = 32'h0000_2000; memindata = 32'h0BAD_F00D;
    tick();
    rst = 0;
    acks = 0; last_c = -1; exp_port = 0;
    for (int c = 0; c < 60 && acks < 4; c++) begin
      tick();
      if (m0_ack_o[1] === 1'b1 || m1_ack_o[1] === 1'b1) begin
        n_cmp++;
        if ({m1_ack_o[1], m0_ack_o[1]} !== (exp_port == 1 ? 2'b10 : 2'b01)) begin
          n_err++;
          $display("FAIL rr_order%0d: got ack1/ack0=%b%b, want port %0d", acks, m1_ack_o[1], m0_ack_o[1], exp_port);
        end
        if (last_c >= 0) begin
          n_cmp++;
          if (c - last_c !== 5) begin
            n_err++;
            $display("FAIL rr_spacing%0d: got %0d cycles, want 5", acks, c - last_c);
          end
        end
        last_c = c;
        exp_port = 1 - exp_port;
        acks++;
      end
    end
    m0_req = 0; m1_req = 0;
    n_cmp++;
    if (acks !== 4) begin
      n_err++;
      $display("FAIL rr_count: got %0d acks, want 4", acks);
    end
    tick(); tick();
  endtask

  task automatic test_back_to_back();
    int n_op, n_ack;
    do_reset();
    m0_req = 1; m0_we = 0; m0_addr = 32'h0000_0040; memindata = 32'h1234_5678;
    n_op = 0; n_ack = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (memop_o[0] !== 32'd0) n_op++;
      if (m0_ack_o[0] === 1'b1) n_ack++;
      if (i == 2) m0_req = 0;
    end
    n_cmp++;
    if (n_op !== 1 || n_ack !== 1) begin
      n_err++;
      $display("FAIL held_req_single: got %0d access cycles %0d acks, want 1 1", n_op, n_ack);
    end
  endtask

  task automatic test_reset_mid_access();
    int n_ack;
    do_reset();
    m0_req = 1; m0_we = 1; m0_addr = 32'h0000_0080; m0_wdata = 32'hA5A5_5A5A;
    tick();
    tick();
    n_cmp++;
    if (memop_o[2] !== 32'd2) begin
      n_err++;
      $display("FAIL midrst_pre: got op=%h, want 2", memop_o[2]);
    end
    rst = 1;
    tick();
    n_cmp++;
    if (memop_o[2] !== 32'd0 || memaddr_o[2] !== 32'd0 || m0_ack_o[2] !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_clear: got op=%h addr=%h ack=%b, want 0 0 0", memop_o[2], memaddr_o[2], m0_ack_o[2]);
    end
    rst = 0;
    n_ack = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (m0_ack_o[2] === 1'b1) n_ack++;
      n_cmp++;
      if (memop_o[2] !== 32'd2 || memout_o[2] !== 32'hA5A5_5A5A) begin
        n_err++;
        $display("FAIL midrst_restart%0d: got op=%h out=%h, want 2 a5a55a5a", i, memop_o[2], memout_o[2]);
      end
    end
    tick();
    n_cmp++;
    if (m0_ack_o[2] !== 1'b1 || n_ack !== 0) begin
      n_err++;
      $display("FAIL midrst_ack: got ack=%b early_acks=%0d, want 1 0", m0_ack_o[2], n_ack);
    end
    m0_req = 0; m0_we = 0;
    tick();
  endtask

  task automatic test_read_then_write();
    do_reset();
    m0_req = 1; m0_we = 0; m0_addr = 32'h0000_0100; memindata = 32'h1111_2222;
    tick(); tick();
    n_cmp++;
    if (m0_ack_o[0] !== 1'b1 || m0_rdata_o[0] !== 32'h1111_2222) begin
      n_err++;
      $display("FAIL rw_read: got ack=%b rd=%h, want 1 11112222", m0_ack_o[0], m0_rdata_o[0]);
    end
    m0_req = 0;
    tick();
    m0_req = 1; m0_we = 1; m0_wdata = 32'hCAFE_F00D; memindata = 32'h9999_9999;
    tick();
    n_cmp++;
    if (memop_o[0] !== 32'd2 || memout_o[0] !== 32'hCAFE_F00D) begin
      n_err++;
      $display("FAIL rw_write_op: got op=%h out=%h, want 2 cafef00d", memop_o[0], memout_o[0]);
    end
    tick();
    n_cmp++;
    if (m0_ack_o[0] !== 1'b1 || m0_rdata_o[0] !== 32'h1111_2222) begin
      n_err++;
      $display("FAIL rw_write_ack: got ack=%b rd=%h, want 1 11112222", m0_ack_o[0], m0_rdata_o[0]);
    end
    m0_req = 0; m0_we = 0;
    tick();
    n_cmp++;
    if (m0_rdata_o[0] !== 32'h1111_2222) begin
      n_err++;
      $display("FAIL rw_hold: got rd=%h, want 11112222", m0_rdata_o[0]);
    end
  endtask

  task automatic test_req_drop();
    do_reset();
    m1_req = 1; m1_we = 0; m1_addr = 32'h0000_0200; memindata = 32'h7777_0001;
    tick();
    m1_req = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (memop_o[2] !== 32'd1 || memaddr_o[2] !== 32'h0000_0200) begin
        n_err++;
        $display("FAIL drop_access%0d: got op=%h addr=%h, want 1 00000200", i, memop_o[2], memaddr_o[2]);
      end
    end
    tick();
    n_cmp++;
    if (m1_ack_o[2] !== 1'b1 || m1_rdata_o[2] !== 32'h7777_0001 || m0_ack_o[2] !== 1'b0) begin
      n_err++;
      $display("FAIL drop_ack: got ack1=%b rd1=%h ack0=%b, want 1 77770001 0", m1_ack_o[2], m1_rdata_o[2], m0_ack_o[2]);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_round_robin();
    test_back_to_back();
    test_reset_mid_access();
    test_read_then_write();
    test_req_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The parameter SHALL be: MEM_LATENCY, default 1, cycles memop is held before memindata is sampled (legal 1..15).
REQ-002 The ports SHALL be as follows, one per line (name, direction, width, meaning):
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, synchronous, active-high.
- m0_req  input  1  port 0 (instruction fetch) request.
- m0_we  input  1  port 0 write enable; 0 = read.
- m0_addr  input  32  port 0 byte address.
- m0_wdata  input  32  port 0 write data.
- m0_ack  output  1  port 0 completion pulse.
- m0_rdata  output  32  port 0 read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata: same directions and widths as port 0, for port 1 (data load/store).
- memop  output  32  memory command: 0 idle, 1 read, 2 write.
- memaddress  output  32  memory address.
- memoutdata  output  32  memory write data.
- memindata  input  32  memory read data.

Function
REQ-003 All outputs SHALL be registered.
REQ-004 The state machine SHALL have three states: IDLE, ACCESS and RESP.
REQ-005 Requester protocol: a requester SHALL hold req, we, addr and wdata stable from req assertion until it sees ack high.
- ack is a single-cycle pulse.
- rdata is valid in the ack cycle for reads.
REQ-006 IDLE, no req: memop SHALL be 0 and the arbiter SHALL stay in IDLE.
REQ-007 IDLE, one or both req high at an edge: the arbiter SHALL grant one port, latch its we/addr/wdata and enter ACCESS.
- memop = 1 (read) or 2 (write), memaddress = addr, memoutdata = wdata.
- A cycle counter is loaded with MEM_LATENCY.
REQ-008 Single requester: that port SHALL be granted.
REQ-009 Both requesting: the port not granted last SHALL win (round-robin). The last-grant pointer resets to port 1, so port 0 wins the first tie.
REQ-010 The last-grant pointer SHALL update only when a grant is made.
REQ-011 ACCESS: memop, memaddress and memoutdata SHALL be held constant for exactly MEM_LATENCY cycles, and the counter SHALL decrement each cycle.
REQ-012 On the edge ending the last ACCESS cycle, the arbiter SHALL enter RESP and set memop to 0.
- For reads, memindata is captured into the granted port's rdata.
REQ-013 RESP: the granted port's ack SHALL be 1 for exactly one cycle; the other port's ack stays 0. The next edge returns to IDLE.
REQ-014 Req inputs SHALL be ignored in ACCESS and RESP, so a req still high during the ack cycle causes no second grant.
REQ-015 Timing: with req first sampled high at the end of cycle T:
- memop is nonzero in cycles T+1..T+MEM_LATENCY;
- ack is high in cycle T+MEM_LATENCY+1;
- the earliest next grant is sampled at the end of cycle T+MEM_LATENCY+2.
REQ-016 Writes SHALL NOT modify rdata, and each rdata SHALL hold its value until that port's next read completes.
REQ-017 memaddress and memoutdata SHALL retain their last values while in IDLE; only memop returns to 0.
REQ-018 A port whose req stays high while the other is served SHALL be granted at the next IDLE sample.
- With both ports requesting continuously, grants strictly alternate, so neither port starves.
REQ-019 m*_req dropping without ack (protocol violation) SHALL NOT abort a transaction already in ACCESS; it completes and acks normally.

Reset
REQ-020 While rst is high at an edge, the block SHALL enter IDLE and clear its outputs and state: memop=0, memaddress=0, memoutdata=0, m0_ack=m1_ack=0, m0_rdata=m1_rdata=0, last-grant pointer = port 1, counter = 0.
REQ-021 Reset in ACCESS or RESP SHALL abandon the transaction with no ack issued. After reset release, the first sample of req occurs in IDLE at the next edge.

Verification
REQ-022 Single read, MEM_LATENCY=1: m0_req=1, m0_we=0, m0_addr=0x400000, memindata=0x3C010040 -> memop=1 and memaddress=0x400000 for 1 cycle; next cycle m0_ack=1, m0_rdata=0x3C010040; m1_ack stays 0.
REQ-023 Single write, MEM_LATENCY=3: m1_req=1, m1_we=1, m1_addr=0x10010000, m1_wdata=0xDEADBEEF -> memop=2, memoutdata=0xDEADBEEF for exactly 3 cycles; then m1_ack=1 for 1 cycle; m1_rdata unchanged (0).
REQ-024 Simultaneous requests held after reset -> grant order port0, port1, port0, port1; each ack spaced MEM_LATENCY+2 cycles apart.
REQ-025 Requester keeps req high during the ack cycle, then drops it -> exactly one memory transaction and one ack.
REQ-026 rst asserted in the 2nd ACCESS cycle with MEM_LATENCY=4 -> next cycle memop=0, no ack ever; after release, a held request restarts with a full 4-cycle access.
REQ-027 Read on port 0 then write on port 0 -> m0_rdata keeps the read value through and after the write ack.
